// File: rtl/framebuffer_write_arbiter_pkg.sv
// framebuffer_write_arbiter_pkg: framebuffer constants, colours, opcodes and arbiter state type
//   Shared by the write arbiter, its priority picker and the instruction engine.
package framebuffer_write_arbiter_pkg;
    localparam int FB_BITS_PER_PIXEL = 3;
    localparam int FB_DEPTH          = 640 * 480;
    localparam logic [FB_BITS_PER_PIXEL-1:0] RED   = 3'b100;
    localparam logic [FB_BITS_PER_PIXEL-1:0] GREEN = 3'b010;
    localparam logic [FB_BITS_PER_PIXEL-1:0] BLUE  = 3'b001;
    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_PIXEL = 8'h01;
    localparam logic [7:0] OP_FILL_RECT = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h03;
    typedef enum logic {s_IDLE, s_GRANT} state_t;
endpackage

// File: rtl/framebuffer_write_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin winner search
//   i_Req    : request vector
//   i_Ptr    : index of the last owner; the search starts at i_Ptr+1 (mod N)
//   o_Winner : one-hot winner, 0 when nothing requests
//   o_Any    : any request present
module rr_priority_picker
    import framebuffer_write_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_Req,
    input  logic [IW-1:0] i_Ptr,
    output logic [N-1:0]  o_Winner,
    output logic          o_Any
);
    localparam logic [N-1:0] ONE = N'(1);
    logic [IW-1:0] w_Idx;
    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        o_Winner = '0;
        w_Idx    = '0;
        for (int i = N; i >= 1; i--) begin
            w_Idx = IW'((int'(i_Ptr) + i) % N);
            if (i_Req[w_Idx]) o_Winner = ONE << w_Idx;
        end
    end
    assign o_Any = |i_Req;
endmodule

// File: rtl/framebuffer_write_arbiter.sv
// framebuffer_write_arbiter: round-robin, burst-locked sharing of the framebuffer write port
//   i_Clock, i_Reset_n          : clock, async active-low reset
//   i_Req_Valid/Last/Addr/Data  : per-requester beat stream, packed [k*W +: W]
//   o_Req_Ready                 : beat accepted when valid & ready
//   i_Stall                     : RAM port busy, blocks all acceptance
//   o_Grant                     : one-hot owner, 0 when idle
//   o_Write_Enable/Addr/Data    : registered framebuffer write, 1 cycle after accept
//   o_Addr_Error                : 1-cycle pulse for an accepted out-of-range beat
module framebuffer_write_arbiter
    import framebuffer_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ           = 2,
    parameter int BITS_PER_PIXEL    = FB_BITS_PER_PIXEL,
    parameter int ADDR_WIDTH        = 32,
    parameter int FRAMEBUFFER_DEPTH = FB_DEPTH,
    parameter int MAX_BURST         = 16
) (
    input  logic                              i_Clock,
    input  logic                              i_Reset_n,
    input  logic [NUM_REQ-1:0]                i_Req_Valid,
    input  logic [NUM_REQ-1:0]                i_Req_Last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     i_Req_Addr,
    input  logic [NUM_REQ*BITS_PER_PIXEL-1:0] i_Req_Data,
    output logic [NUM_REQ-1:0]                o_Req_Ready,
    input  logic                              i_Stall,
    output logic [NUM_REQ-1:0]                o_Grant,
    output logic                              o_Write_Enable,
    output logic [ADDR_WIDTH-1:0]             o_Write_Addr,
    output logic [BITS_PER_PIXEL-1:0]         o_Write_Data,
    output logic                              o_Addr_Error
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    state_t                    r_State;
    logic [IW-1:0]             r_Owner, r_Last_Grant, w_Win_Idx;
    logic [CW-1:0]             r_Beat_Count;
    logic [NUM_REQ-1:0]        w_Winner;
    logic                      w_Any, w_Valid, w_Accept, w_In_Range, w_Release;
    logic [ADDR_WIDTH-1:0]     w_Addr;
    logic [BITS_PER_PIXEL-1:0] w_Data;
    rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .i_Req    (i_Req_Valid),
        .i_Ptr    (r_Last_Grant),
        .o_Winner (w_Winner),
        .o_Any    (w_Any)
    );
    always_comb begin
        w_Win_Idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (w_Winner[i]) w_Win_Idx = IW'(i);
    end
    assign w_Valid     = i_Req_Valid[r_Owner];
    assign w_Addr      = i_Req_Addr[r_Owner*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_Data      = i_Req_Data[r_Owner*BITS_PER_PIXEL +: BITS_PER_PIXEL];
    assign w_In_Range  = 64'(w_Addr) < 64'(FRAMEBUFFER_DEPTH);
    assign o_Req_Ready = (r_State == s_GRANT && !i_Stall) ? o_Grant : '0;
    assign w_Accept    = r_State == s_GRANT && w_Valid && !i_Stall;
    // A dropped valid ends the burst even while stalled; the owner must re-arbitrate.
    assign w_Release   = r_State == s_GRANT && (!w_Valid || (w_Accept &&
                         (i_Req_Last[r_Owner] || r_Beat_Count == CW'(MAX_BURST - 1))));
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State        <= s_IDLE;
            r_Owner        <= '0;
            r_Last_Grant   <= IW'(NUM_REQ - 1);
            r_Beat_Count   <= '0;
            o_Grant        <= '0;
            o_Write_Enable <= 1'b0;
            o_Write_Addr   <= '0;
            o_Write_Data   <= '0;
            o_Addr_Error   <= 1'b0;
        end else begin
            o_Write_Enable <= w_Accept && w_In_Range;
            o_Addr_Error   <= w_Accept && !w_In_Range;
            // Suppressed beats leave the last real write's address and data on the port.
            if (w_Accept && w_In_Range) begin
                o_Write_Addr <= w_Addr;
                o_Write_Data <= w_Data;
            end
            if (r_State == s_IDLE) begin
                if (w_Any) begin
                    r_State      <= s_GRANT;
                    o_Grant      <= w_Winner;
                    r_Owner      <= w_Win_Idx;
                    r_Beat_Count <= '0;
                end
            end else begin
                if (w_Accept) r_Beat_Count <= r_Beat_Count + CW'(1);
                if (w_Release) begin
                    r_State      <= s_IDLE;
                    o_Grant      <= '0;
                    r_Last_Grant <= r_Owner;
                end
            end
        end
    end
endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// tb_framebuffer_write_arbiter: scoreboard bench with directed bursts and random traffic
module tb_framebuffer_write_arbiter;
    localparam int N = 2, AW = 32, BPP = 3, DEPTH = 640 * 480, MAXB = 16;
    typedef struct {
        logic [AW-1:0]  addr;
        logic [BPP-1:0] data;
        bit             err;
        int             cyc;
    } exp_t;
    logic clk = 0, rst_n = 1, stall = 0;
    logic [N-1:0] v = '0, last = '0, rdy, gnt, dut_acc;
    logic [AW-1:0] a[N];
    logic [BPP-1:0] d[N];
    logic [N*AW-1:0] addr_bus;
    logic [N*BPP-1:0] data_bus;
    logic we, err;
    logic [AW-1:0] wa;
    logic [BPP-1:0] wd;
    int checks = 0, errors = 0, cyc = 0;
    int m_own = -1, m_last = N - 1, m_cnt = 0;
    logic [AW-1:0] m_wa = '0;
    logic [BPP-1:0] m_wd = '0;
    logic [N-1:0] prev_gnt = '0;
    int seq[$];
    int run = 0, max_run = 0, n_we = 0;
    exp_t q[$];
    exp_t mon_e;

    assign addr_bus = {a[1], a[0]};
    assign data_bus = {d[1], d[0]};

    framebuffer_write_arbiter #(
        .NUM_REQ(N), .BITS_PER_PIXEL(BPP), .ADDR_WIDTH(AW),
        .FRAMEBUFFER_DEPTH(DEPTH), .MAX_BURST(MAXB)
    ) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_Req_Valid(v), .i_Req_Last(last), .i_Req_Addr(addr_bus), .i_Req_Data(data_bus),
        .o_Req_Ready(rdy), .i_Stall(stall), .o_Grant(gnt),
        .o_Write_Enable(we), .o_Write_Addr(wa), .o_Write_Data(wd), .o_Addr_Error(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the expected beat whenever the write port shows a write or an error.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (we || err) begin
                if (we) n_we++;
                if (q.size() == 0) chk("unexpected_output", {62'b0, we, err}, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("out_kind", {62'b0, we, err}, mon_e.err ? 64'd1 : 64'd2);
                    chk("out_latency", cyc, mon_e.cyc);
                    if (!mon_e.err) begin
                        chk("write_addr", wa, mon_e.addr);
                        chk("write_data", wd, mon_e.data);
                        m_wa = mon_e.addr;
                        m_wd = mon_e.data;
                    end
                end
            end else begin
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    mon_e = q.pop_front();
                    chk("missing_output", {62'b0, we, err}, mon_e.err ? 64'd1 : 64'd2);
                end
                chk("hold_addr", wa, m_wa);
                chk("hold_data", wd, m_wd);
            end
        end
    end

    // One clock of the reference model: who owns the port, what gets accepted, who is next.
    task automatic tick();
        logic [N-1:0] er;
        #1;
        er = (m_own >= 0 && !stall) ? N'(1) << m_own : '0;
        chk("ready", rdy, er);
        dut_acc = rdy & v;
        if (dut_acc[1]) begin
            run++;
            if (run > max_run) max_run = run;
        end else run = 0;
        if (m_own < 0) begin
            for (int i = 1; i <= N; i++) if (m_own < 0 && v[(m_last + i) % N]) m_own = (m_last + i) % N;
            m_cnt = 0;
        end else if (!v[m_own]) begin
            m_last = m_own;
            m_own  = -1;
        end else if (!stall) begin
            q.push_back('{addr: a[m_own], data: d[m_own], err: (a[m_own] >= DEPTH), cyc: cyc + 1});
            m_cnt++;
            if (last[m_own] || m_cnt == MAXB) begin
                m_last = m_own;
                m_own  = -1;
            end
        end
        @(posedge clk);
        #1;
        chk("grant", gnt, m_own < 0 ? '0 : N'(1) << m_own);
        if (gnt != 0 && prev_gnt == 0) seq.push_back(int'(gnt));
        prev_gnt = gnt;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 0;
        #1;
        chk("rst_grant", gnt, 0);
        chk("rst_ready", rdy, 0);
        chk("rst_we", we, 0);
        chk("rst_err", err, 0);
        v = '0;
        last = '0;
        stall = 0;
        q.delete();
        m_own = -1; m_last = N - 1; m_cnt = 0; m_wa = '0; m_wd = '0; prev_gnt = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    task automatic burst(int k, int n, bit use_last, int stall_after, int bad_idx, int rst_after);
        int i = 0, g = 0;
        while (i < n && g < 200) begin
            v[k] = 1;
            a[k] = (i == bad_idx) ? AW'(DEPTH) : AW'(i);
            d[k] = (k == 0) ? 3'b100 : BPP'(i);
            last[k] = use_last && i == n - 1;
            if (i == rst_after) begin
                do_reset();
                return;
            end
            if (i == stall_after) begin
                stall = 1;
                repeat (5) tick();
                stall = 0;
                stall_after = -1;
            end
            tick();
            g++;
            if (dut_acc[k]) i++;
        end
        if (g >= 200) chk("burst_timeout", i, n);
        v[k] = 0;
        last[k] = 0;
    endtask

    initial begin
        a = '{default: '0};
        d = '{default: '0};
        #1;
        do_reset();
        n_we = 0;
        burst(0, 4, 1, -1, -1, -1);
        repeat (3) tick();
        chk("t1_writes", n_we, 4);
        do_reset();
        seq.delete();
        v = 2'b11;
        last = 2'b11;
        repeat (10) tick();
        chk("t2_grants_seen", seq.size() >= 4, 1);
        for (int i = 0; i < 4 && i < seq.size(); i++) chk("t2_order", seq[i], (i % 2 == 0) ? 1 : 2);
        v = '0;
        last = '0;
        repeat (2) tick();
        v[0] = 1;
        last[0] = 1;
        a[0] = 100;
        d[0] = 3'b010;
        run = 0;
        max_run = 0;
        burst(1, 40, 0, -1, -1, -1);
        v = '0;
        last = '0;
        repeat (2) tick();
        chk("t3_max_run", max_run, MAXB);
        burst(0, 10, 1, 3, -1, -1);
        repeat (2) tick();
        burst(0, 4, 1, -1, 1, -1);
        repeat (2) tick();
        burst(0, 8, 1, -1, -1, 3);
        v = 2'b11;
        tick();
        chk("post_reset_grant", gnt, 1);
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) begin
                v[k] = $urandom_range(0, 9) < 8;
                last[k] = $urandom_range(0, 4) == 0;
                a[k] = ($urandom_range(0, 9) == 0) ? AW'(DEPTH + $urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
                d[k] = BPP'($urandom);
            end
            stall = $urandom_range(0, 6) == 0;
            tick();
        end
        v = '0;
        stall = 0;
        repeat (4) tick();
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
